// File: rtl/vidac_gen.sv
// Command-list video accelerator: fetches END/LINE/RECT/PSET commands from shared
// video memory and draws them, clipped, into a linear 8-bpp framebuffer.
module vidac_gen #(
    parameter int AW       = 17,
    parameter int SCR_W    = 320,
    parameter int SCR_H    = 200,
    parameter int FB_BASE  = 0,
    parameter int CMD_BASE = 'h10000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cmd,
    input  logic          abort,
    output logic [AW-1:0] a,
    input  logic [7:0]    i,
    output logic [7:0]    o,
    output logic          w,
    output logic          bsy,
    output logic          err
);
    localparam logic [AW-1:0]      CMD_A = AW'(CMD_BASE);
    localparam logic signed [15:0] W16   = 16'(SCR_W);
    localparam logic signed [15:0] H16   = 16'(SCR_H);
    localparam logic [1:0] OP_LINE = 2'd1;
    localparam logic [1:0] OP_RECT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_PARAM, S_LSETUP,
        S_LPLOT, S_RSETUP, S_RFILL, S_PSET, S_NEXT
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, a_q, a_d, row_q, row_d, addr_q, addr_d;
    logic [7:0]    o_q, o_d;
    logic          w_q, w_d, bsy_q, bsy_d, err_q, err_d;
    logic [1:0]    op_q, op_d;
    logic [3:0]    idx_q, idx_d;
    logic signed [15:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic signed [15:0] x_q, x_d, y_q, y_d, dx_q, dx_d, dy_q, dy_d;
    logic          sx_q, sx_d, sy_q, sy_d;
    logic signed [16:0] acc_q, acc_d;
    logic signed [17:0] e2;

    function automatic logic [AW-1:0] pix_addr(input logic signed [15:0] px,
                                               input logic signed [15:0] py);
        return AW'(FB_BASE) + AW'(py) * AW'(SCR_W) + AW'(px);
    endfunction

    function automatic logic on_screen(input logic signed [15:0] px,
                                       input logic signed [15:0] py);
        return (px >= 16'sd0) && (px < W16) && (py >= 16'sd0) && (py < H16);
    endfunction

    // Line setup terms
    logic signed [15:0] ldx, ldy, ldx_abs, ldy_abs;
    assign ldx     = x2_q - x1_q;
    assign ldy     = y2_q - y1_q;
    assign ldx_abs = (ldx < 16'sd0) ? -ldx : ldx;
    assign ldy_abs = (ldy < 16'sd0) ? -ldy : ldy;

    // Rectangle normalisation and clamping
    logic signed [15:0] rx_lo, rx_hi, ry_lo, ry_hi, rx_lo_c, rx_hi_c, ry_lo_c, ry_hi_c;
    logic               rect_off;
    assign rx_lo    = (x1_q < x2_q) ? x1_q : x2_q;
    assign rx_hi    = (x1_q < x2_q) ? x2_q : x1_q;
    assign ry_lo    = (y1_q < y2_q) ? y1_q : y2_q;
    assign ry_hi    = (y1_q < y2_q) ? y2_q : y1_q;
    assign rect_off = (rx_hi < 16'sd0) || (ry_hi < 16'sd0) || (rx_lo >= W16) || (ry_lo >= H16);
    assign rx_lo_c  = (rx_lo < 16'sd0) ? 16'sd0 : rx_lo;
    assign ry_lo_c  = (ry_lo < 16'sd0) ? 16'sd0 : ry_lo;
    assign rx_hi_c  = (rx_hi > W16 - 16'sd1) ? W16 - 16'sd1 : rx_hi;
    assign ry_hi_c  = (ry_hi > H16 - 16'sd1) ? H16 - 16'sd1 : ry_hi;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        o_d     = o_q;
        w_d     = 1'b0;
        bsy_d   = bsy_q;
        err_d   = err_q;
        op_d    = op_q;
        idx_d   = idx_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        acc_d   = acc_q;
        row_d   = row_q;
        addr_d  = addr_q;
        e2      = {acc_q, 1'b0};

        case (state_q)
            S_IDLE: begin
                if (cmd) begin
                    bsy_d   = 1'b1;
                    err_d   = 1'b0;
                    ptr_d   = CMD_A;
                    a_d     = CMD_A;
                    state_d = S_FETCH;
                end
            end
            // Memory reads are one cycle late, so the address bus always runs one byte ahead
            S_FETCH: begin
                a_d     = ptr_q + AW'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ptr_d = ptr_q + AW'(1);
                a_d   = ptr_q + AW'(2);
                idx_d = 4'd0;
                case (i)
                    8'h00: begin
                        bsy_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                    8'h01, 8'h02, 8'h03: begin
                        op_d    = i[1:0];
                        state_d = S_PARAM;
                    end
                    default: begin
                        bsy_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_PARAM: begin
                ptr_d = ptr_q + AW'(1);
                a_d   = ptr_q + AW'(2);
                idx_d = idx_q + 4'd1;
                case (idx_q)
                    4'd0: x1_d[7:0]  = i;
                    4'd1: x1_d[15:8] = i;
                    4'd2: y1_d[7:0]  = i;
                    4'd3: y1_d[15:8] = i;
                    4'd4: x2_d[7:0]  = i;
                    4'd5: x2_d[15:8] = i;
                    4'd6: y2_d[7:0]  = i;
                    4'd7: y2_d[15:8] = i;
                    default: ;
                endcase
                if (idx_q == ((op_q == OP_LINE || op_q == OP_RECT) ? 4'd8 : 4'd4)) begin
                    o_d = i;
                    if (op_q == OP_LINE)      state_d = S_LSETUP;
                    else if (op_q == OP_RECT) state_d = S_RSETUP;
                    else                      state_d = S_PSET;
                end
            end
            S_PSET: begin
                a_d     = pix_addr(x1_q, y1_q);
                w_d     = on_screen(x1_q, y1_q);
                state_d = S_NEXT;
            end
            S_LSETUP: begin
                dx_d    = ldx_abs;
                dy_d    = -ldy_abs;
                sx_d    = ldx < 16'sd0;
                sy_d    = ldy < 16'sd0;
                acc_d   = 17'(ldx_abs) - 17'(ldy_abs);
                x_d     = x1_q;
                y_d     = y1_q;
                state_d = S_LPLOT;
            end
            S_LPLOT: begin
                a_d = pix_addr(x_q, y_q);
                w_d = on_screen(x_q, y_q);
                if (x_q == x2_q && y_q == y2_q) begin
                    state_d = S_NEXT;
                end else begin
                    // Both steps test the same pre-update e2
                    if (e2 >= 18'(dy_q)) begin
                        acc_d = acc_d + 17'(dy_q);
                        x_d   = sx_q ? x_q - 16'sd1 : x_q + 16'sd1;
                    end
                    if (e2 <= 18'(dx_q)) begin
                        acc_d = acc_d + 17'(dx_q);
                        y_d   = sy_q ? y_q - 16'sd1 : y_q + 16'sd1;
                    end
                end
            end
            S_RSETUP: begin
                x_d     = rx_lo_c;
                y_d     = ry_lo_c;
                x1_d    = rx_lo_c;
                x2_d    = rx_hi_c;
                y2_d    = ry_hi_c;
                addr_d  = pix_addr(rx_lo_c, ry_lo_c);
                row_d   = pix_addr(rx_lo_c, ry_lo_c);
                state_d = rect_off ? S_NEXT : S_RFILL;
            end
            S_RFILL: begin
                a_d = addr_q;
                w_d = 1'b1;
                if (x_q == x2_q) begin
                    if (y_q == y2_q) begin
                        state_d = S_NEXT;
                    end else begin
                        x_d    = x1_q;
                        y_d    = y_q + 16'sd1;
                        row_d  = row_q + AW'(SCR_W);
                        addr_d = row_q + AW'(SCR_W);
                    end
                end else begin
                    x_d    = x_q + 16'sd1;
                    addr_d = addr_q + AW'(1);
                end
            end
            // Lets the final pixel leave the output registers before the next opcode address
            S_NEXT: begin
                a_d     = ptr_q;
                state_d = S_FETCH;
            end
            default: begin
                bsy_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (bsy_q && abort) begin
            bsy_d   = 1'b0;
            w_d     = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            o_q     <= '0;
            w_q     <= 1'b0;
            bsy_q   <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            idx_q   <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            acc_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            o_q     <= o_d;
            w_q     <= w_d;
            bsy_q   <= bsy_d;
            err_q   <= err_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    assign a   = a_q;
    assign o   = o_q;
    assign w   = w_q;
    assign bsy = bsy_q;
    assign err = err_q;
endmodule

// File: tb/tb_vidac_gen.sv
// Directed bench for vidac_gen: synchronous-read memory model, write logger and
// hand-computed expected write sequences.
`timescale 1ns/1ps
module tb_vidac_gen;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd = 1'b0;
    logic        abort = 1'b0;
    logic [16:0] a;
    logic [7:0]  i;
    logic [7:0]  o;
    logic        w, bsy, err;

    vidac_gen dut (
        .clock(clock), .reset_n(reset_n), .cmd(cmd), .abort(abort),
        .a(a), .i(i), .o(o), .w(w), .bsy(bsy), .err(err)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:131071];
    always @(posedge clock) i <= mem[a];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int wa[$], wo[$], wc[$];
    always @(negedge clock) begin
        if (w === 1'b1) begin
            wa.push_back(int'(a));
            wo.push_back(int'(o));
            wc.push_back(cyc);
        end
    end

    int n_total = 0, n_pass = 0, n_fail = 0;
    logic [7:0] lst[$];
    int ea[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load();
        foreach (lst[k]) mem[32'h10000 + k] = lst[k];
        wa.delete(); wo.delete(); wc.delete();
    endtask

    task automatic start();
        @(posedge clock); #1 cmd = 1'b1;
        @(posedge clock); #1 cmd = 1'b0;
    endtask

    task automatic run(output int ncyc);
        load();
        start();
        ncyc = 0;
        @(negedge clock);
        while (bsy !== 1'b0 && ncyc < 5000) begin
            @(negedge clock);
            ncyc++;
        end
        chk("bsy_fall", int'(bsy), 0);
    endtask

    task automatic chk_list(input string tag);
        chk({tag, "_count"}, wa.size(), ea.size());
        foreach (ea[k]) chk({tag, "_addr"}, (k < wa.size()) ? wa[k] : -1, ea[k]);
    endtask

    int n, a0, nw;

    initial begin
        foreach (mem[k]) mem[k] = 8'h00;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_a", int'(a), 0);
        chk("rst_o", int'(o), 0);
        chk("rst_w", int'(w), 0);
        chk("rst_bsy", int'(bsy), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // PSET (10,5) c=2A
        lst = '{8'h03, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h2A, 8'h00};
        run(n);
        ea = '{1610};
        chk_list("pset");
        chk("pset_o", (wo.size() > 0) ? wo[0] : -1, 'h2A);
        chk("pset_err", int'(err), 0);
        $display("pset (10,5): writes=%0d", wa.size());

        // Horizontal line (0,0)-(3,0)
        lst = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
        run(n);
        ea = '{0, 1, 2, 3};
        chk_list("hline");
        chk("hline_consec", (wc.size() == 4) ? wc[3] - wc[0] : -1, 3);
        chk("hline_o", (wo.size() == 4) ? wo[3] : -1, 'h11);
        $display("line (0,0)-(3,0): writes=%0d", wa.size());

        // Reverse diagonal (3,3)-(0,0)
        lst = '{8'h01, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00};
        run(n);
        ea = '{963, 642, 321, 0};
        chk_list("rdiag");
        $display("line (3,3)-(0,0): writes=%0d", wa.size());

        // Diagonal starting off-screen (-1,-1)-(1,1)
        lst = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00, 8'h33, 8'h00};
        run(n);
        ea = '{0, 321};
        chk_list("clipdiag");
        $display("line (-1,-1)-(1,1): writes=%0d", wa.size());

        // Steep line (0,0)-(2,5): x = 0,0,1,1,2,2
        lst = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00, 8'h44, 8'h00};
        run(n);
        ea = '{0, 320, 641, 961, 1282, 1602};
        chk_list("steep");
        $display("line (0,0)-(2,5): writes=%0d", wa.size());

        // RECT (1,1)-(-2,-2): swapped and clamped to (0,0)-(1,1)
        lst = '{8'h02, 8'h01, 8'h00, 8'h01, 8'h00, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'h55, 8'h00};
        run(n);
        ea = '{0, 1, 320, 321};
        chk_list("rect");
        chk("rect_o", (wo.size() > 0) ? wo[0] : -1, 'h55);
        $display("rect (1,1)-(-2,-2): writes=%0d", wa.size());

        // Off-screen RECT, then PSET (1,0) c=77
        lst = '{8'h02, 8'h90, 8'h01, 8'h00, 8'h00, 8'hF4, 8'h01, 8'h0A, 8'h00, 8'h33,
                8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00};
        run(n);
        ea = '{1};
        chk_list("offrect");
        chk("offrect_o", (wo.size() > 0) ? wo[0] : -1, 'h77);
        $display("rect (400,0)-(500,10) + pset: writes=%0d", wa.size());

        // Unknown opcode
        lst = '{8'h7F};
        run(n);
        chk("badop_cycles", int'(n <= 3), 1);
        chk("badop_err", int'(err), 1);
        chk("badop_nowrite", wa.size(), 0);
        $display("opcode 7F: cycles=%0d err=%0d", n, err);
        lst = '{8'h03, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h2A, 8'h00};
        run(n);
        chk("err_cleared", int'(err), 0);
        $display("pset after error: err=%0d", err);

        // Long LINE (0,0)-(300,0): cmd ignored, then abort
        lst = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C, 8'h01, 8'h00, 8'h00, 8'h99, 8'h00};
        load();
        start();
        repeat (30) @(negedge clock);
        a0 = int'(a);
        chk("long_w", int'(w), 1);
        @(posedge clock); #1 cmd = 1'b1;
        @(posedge clock); #1 cmd = 1'b0;
        @(negedge clock);
        chk("cmd_ignored_a", int'(a), a0 + 2);
        chk("cmd_ignored_bsy", int'(bsy), 1);
        @(posedge clock); #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        chk("abort_bsy", int'(bsy), 0);
        chk("abort_w", int'(w), 0);
        nw = wa.size();
        repeat (5) @(negedge clock);
        chk("abort_quiet", wa.size(), nw);
        $display("long line abort: writes=%0d", nw);

        // Long LINE interrupted by reset
        load();
        start();
        repeat (20) @(negedge clock);
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_a", int'(a), 0);
        chk("midrst_o", int'(o), 0);
        chk("midrst_w", int'(w), 0);
        chk("midrst_bsy", int'(bsy), 0);
        @(posedge clock); #1 reset_n = 1'b1;
        $display("long line reset: outputs cleared");

        // Screen corner and just past the right edge
        lst = '{8'h03, 8'h3F, 8'h01, 8'hC7, 8'h00, 8'h66, 8'h00};
        run(n);
        ea = '{63999};
        chk_list("corner");
        $display("pset (319,199): writes=%0d", wa.size());
        lst = '{8'h03, 8'h40, 8'h01, 8'h00, 8'h00, 8'h66, 8'h00};
        run(n);
        chk("edge_nowrite", wa.size(), 0);
        $display("pset (320,0): writes=%0d", wa.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
